// File: rtl/leaf_pte_ad_update_unit.sv
// Leaf PTE validity/permission/alignment check with optional hardware
// A/D write-back; one request in flight, answered over valid/ready.
module leaf_pte_ad_update_unit #(
    parameter int PTE_SIZE_IN_BIT = 64,
    parameter int PADDR_WIDTH     = 56,
    parameter int LEVELS          = 3,
    parameter bit HW_AD_UPDATE    = 1'b1,
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_access_mode_i,
    input  logic [1:0]                 req_priv_i,
    input  logic                       req_mxr_i,
    input  logic                       req_sum_i,
    input  logic [LVL_W-1:0]           req_level_i,
    input  logic [PTE_SIZE_IN_BIT-1:0] req_pte_i,
    input  logic [PADDR_WIDTH-1:0]     req_pte_addr_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic                       resp_fault_o,
    output logic [2:0]                 resp_cause_o,
    output logic [PTE_SIZE_IN_BIT-1:0] resp_pte_o,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [PADDR_WIDTH-1:0]     wb_addr_o,
    output logic [PTE_SIZE_IN_BIT-1:0] wb_data_o,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WB_REQ,
        S_WB_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] CAUSE_OK    = 3'd0;
    localparam logic [2:0] CAUSE_INVAL = 3'd1;
    localparam logic [2:0] CAUSE_PERM  = 3'd2;
    localparam logic [2:0] CAUSE_PRIV  = 3'd3;
    localparam logic [2:0] CAUSE_ALIGN = 3'd4;
    localparam logic [2:0] CAUSE_AD    = 3'd5;
    localparam logic [2:0] CAUSE_WB    = 3'd6;

    state_t                       state_q;
    state_t                       state_d;
    logic [PTE_SIZE_IN_BIT-1:0]   pte_q;
    logic [1:0]                   mode_q;
    logic [1:0]                   priv_q;
    logic                         mxr_q;
    logic                         sum_q;
    logic [LVL_W-1:0]             level_q;

    logic [PTE_SIZE_IN_BIT-1:0]   wb_data_d;
    logic                         fault_d;
    logic [2:0]                   cause_d;
    logic [PTE_SIZE_IN_BIT-1:0]   rpte_d;

    logic                         pte_v;
    logic                         pte_r;
    logic                         pte_w;
    logic                         pte_x;
    logic                         pte_u;
    logic                         pte_a;
    logic                         pte_d;
    logic                         is_write;
    logic                         is_exec;
    logic                         perm_ok;
    logic                         priv_ok;
    logic                         misaligned;
    logic [2:0]                   chk_cause;
    logic [PTE_SIZE_IN_BIT-1:0]   ad_set;
    logic [PTE_SIZE_IN_BIT-1:0]   upd_pte;

    assign pte_v    = pte_q[0];
    assign pte_r    = pte_q[1];
    assign pte_w    = pte_q[2];
    assign pte_x    = pte_q[3];
    assign pte_u    = pte_q[4];
    assign pte_a    = pte_q[6];
    assign pte_d    = pte_q[7];
    assign is_write = (mode_q == 2'b01);
    assign is_exec  = (mode_q == 2'b10);

    always_comb begin
        perm_ok = 1'b0;
        unique case (mode_q)
            2'b00:   perm_ok = pte_r | (pte_x & mxr_q);
            2'b01:   perm_ok = pte_w;
            2'b10:   perm_ok = pte_x;
            default: perm_ok = 1'b0;
        endcase
    end

    // M-mode (and the unused 10 encoding) are checked with S-mode rules.
    assign priv_ok = (priv_q == 2'b00) ? pte_u
                                       : (!pte_u || (sum_q && !is_exec));

    // A superpage leaf must have every PPN field below its level cleared.
    always_comb begin
        misaligned = (int'(level_q) >= LEVELS);
        for (int i = 0; i < LEVELS - 1; i++) begin
            if (i < int'(level_q) && pte_q[10 + 9*i +: 9] != 9'd0) begin
                misaligned = 1'b1;
            end
        end
    end

    always_comb begin
        if (!pte_v || (!pte_r && pte_w)) begin
            chk_cause = CAUSE_INVAL;
        end else if (!perm_ok) begin
            chk_cause = CAUSE_PERM;
        end else if (!priv_ok) begin
            chk_cause = CAUSE_PRIV;
        end else if (misaligned) begin
            chk_cause = CAUSE_ALIGN;
        end else if (!pte_a || (is_write && !pte_d)) begin
            chk_cause = CAUSE_AD;
        end else begin
            chk_cause = CAUSE_OK;
        end
    end

    always_comb begin
        ad_set    = '0;
        ad_set[6] = 1'b1;
        ad_set[7] = is_write;
    end

    assign upd_pte = pte_q | ad_set;

    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_o;
        fault_d   = resp_fault_o;
        cause_d   = resp_cause_o;
        rpte_d    = resp_pte_o;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (chk_cause == CAUSE_AD && HW_AD_UPDATE) begin
                    wb_data_d = upd_pte;
                    state_d   = S_WB_REQ;
                end else begin
                    fault_d = (chk_cause != CAUSE_OK);
                    cause_d = chk_cause;
                    rpte_d  = pte_q;
                    state_d = S_RESP;
                end
            end
            S_WB_REQ: begin
                if (wb_ready_i) state_d = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (wb_ack_i) begin
                    fault_d = wb_err_i;
                    cause_d = wb_err_i ? CAUSE_WB : CAUSE_OK;
                    rpte_d  = wb_data_o;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pte_q        <= '0;
            mode_q       <= '0;
            priv_q       <= '0;
            mxr_q        <= 1'b0;
            sum_q        <= 1'b0;
            level_q      <= '0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            resp_fault_o <= 1'b0;
            resp_cause_o <= CAUSE_OK;
            resp_pte_o   <= '0;
        end else begin
            state_q      <= state_d;
            wb_data_o    <= wb_data_d;
            resp_fault_o <= fault_d;
            resp_cause_o <= cause_d;
            resp_pte_o   <= rpte_d;
            if (state_q == S_IDLE && req_valid_i) begin
                pte_q     <= req_pte_i;
                mode_q    <= req_access_mode_i;
                priv_q    <= req_priv_i;
                mxr_q     <= req_mxr_i;
                sum_q     <= req_sum_i;
                level_q   <= req_level_i;
                wb_addr_o <= req_pte_addr_i;
            end
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign wb_valid_o   = (state_q == S_WB_REQ);

endmodule
